// File: rtl/stream_serializer_if.sv
// Wide-in / narrow-out stream bundle for the lane serializer.
// slave is the serializer side; master is the producer/consumer side.
interface stream_serializer_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N + 1)
);
  logic           input_valid;
  logic           input_ready;
  logic [W*N-1:0] input_payload;
  logic [CW-1:0]  input_count;
  logic           output_valid;
  logic           output_ready;
  logic [W-1:0]   output_payload;
  logic           output_last;

  modport slave (
    input  input_valid, input_payload, input_count, output_ready,
    output input_ready, output_valid, output_payload, output_last
  );

  modport master (
    output input_valid, input_payload, input_count, output_ready,
    input  input_ready, output_valid, output_payload, output_last
  );
endinterface

// File: rtl/stream_serializer.sv
// Valid/ready width downsizer: drains the first input_count lanes of a wide word,
// lane 0 first, one lane per beat, with zero-bubble turnover between words.
module stream_serializer #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_serializer_if.slave   bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [W*N-1:0] data_q,  data_d;
  logic [CW-1:0]  rem_q,   rem_d;
  logic [IW-1:0]  idx_q,   idx_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   payload_q, payload_d;
  logic           last_q,  last_d;

  logic [CW-1:0]  c_sat;
  logic           in_ready;
  logic           accept;
  logic           load;
  logic           out_hs;

  function automatic logic [W-1:0] lane_sel(input logic [W*N-1:0] d, input logic [IW-1:0] i);
    lane_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (IW'(k) == i) lane_sel = d[k*W +: W];
    end
  endfunction

  // Oversized counts saturate to a full word.
  assign c_sat    = (bus.input_count > CW'(N)) ? CW'(N) : bus.input_count;
  assign out_hs   = valid_q && bus.output_ready;
  // Ready is combinational from output_ready so the last beat and the next word share a cycle.
  assign in_ready = (state_q == IDLE) || (out_hs && last_q);
  assign accept   = bus.input_valid && in_ready;
  assign load     = accept && (c_sat != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      payload_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      last_q    <= last_d;
    end
  end

  // Next-state: load a new word, advance a lane, or fall back to IDLE.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = DRAIN;
          data_d    = bus.input_payload;
          idx_d     = '0;
          rem_d     = c_sat;
          valid_d   = 1'b1;
          payload_d = bus.input_payload[W-1:0];
          last_d    = (c_sat == CW'(1));
        end
      end
      DRAIN: begin
        if (load) begin
          data_d    = bus.input_payload;
          idx_d     = '0;
          rem_d     = c_sat;
          valid_d   = 1'b1;
          payload_d = bus.input_payload[W-1:0];
          last_d    = (c_sat == CW'(1));
        end else if (out_hs) begin
          if (!last_q) begin
            idx_d     = idx_q + IW'(1);
            rem_d     = rem_q - CW'(1);
            payload_d = lane_sel(data_q, idx_q + IW'(1));
            last_d    = (rem_q == CW'(2));
          end else begin
            state_d = IDLE;
            rem_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.input_ready    = in_ready;
  assign bus.output_valid   = valid_q;
  assign bus.output_payload = payload_q;
  assign bus.output_last    = last_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: vector table plus multi-cycle corner sequences.
module tb_stream_serializer;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst_n;

  stream_serializer_if #(.W(W), .N(N), .CW(CW)) bus ();

  stream_serializer #(.W(W), .N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] payload;
    logic [2:0]  count;
    int          nbeats;
    logic [31:0] exp_lanes;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer a word and return just after the accepting edge; keep leaves input_valid high.
  task automatic send_word(input logic [31:0] p, input logic [2:0] c, input bit keep);
    bit got;
    got = 1'b0;
    bus.input_valid   = 1'b1;
    bus.input_payload = p;
    bus.input_count   = c;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.input_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    if (!keep) bus.input_valid = 1'b0;
  endtask

  task automatic expect_beat(input string name, input logic [7:0] p, input logic l);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.output_valid), 32'd1);
    check({name, "_payload"}, 32'(bus.output_payload), 32'(p));
    check({name, "_last"}, 32'(bus.output_last), 32'(l));
  endtask

  initial begin
    logic [7:0] bp_pay [5];
    logic       bp_last [5];
    logic       bp_rdy [5];

    vt[0] = '{32'h44332211, 3'd4, 4, 32'h44332211};
    vt[1] = '{32'hFFFFFF5A, 3'd1, 1, 32'h0000005A};
    vt[2] = '{32'h44332211, 3'd7, 4, 32'h44332211};
    vt[3] = '{32'h44332211, 3'd0, 0, 32'h00000000};
    vt[4] = '{32'hDDCCBBAA, 3'd3, 3, 32'h00CCBBAA};
    vt[5] = '{32'h0000BBAA, 3'd2, 2, 32'h0000BBAA};

    rst_n             = 1'b0;
    bus.input_valid   = 1'b0;
    bus.input_payload = '0;
    bus.input_count   = '0;
    bus.output_ready  = 1'b1;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_during", 32'(bus.output_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(bus.output_valid), 32'd0);
    check("rst_last", 32'(bus.output_last), 32'd0);
    check("rst_payload", 32'(bus.output_payload), 32'd0);
    check("rst_in_ready", 32'(bus.input_ready), 32'd1);
    @(posedge clk);
    #1;

    // Table of single words drained with output_ready held high
    for (int v = 0; v < 6; v++) begin
      send_word(vt[v].payload, vt[v].count, 1'b0);
      for (int k = 0; k < vt[v].nbeats; k++) begin
        logic [31:0] lanes;
        logic        is_last;
        lanes   = vt[v].exp_lanes;
        is_last = (k == vt[v].nbeats - 1);
        expect_beat($sformatf("vec%0d_beat%0d", v, k), lanes[k*8 +: 8], is_last);
        check($sformatf("vec%0d_beat%0d_in_ready", v, k), 32'(bus.input_ready), 32'(is_last));
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      check($sformatf("vec%0d_idle_valid", v), 32'(bus.output_valid), 32'd0);
      check($sformatf("vec%0d_idle_in_ready", v), 32'(bus.input_ready), 32'd1);
      @(posedge clk);
      #1;
    end

    // Back-to-back words with no bubble
    begin
      logic [7:0] seq_p [6];
      logic       seq_l [6];
      seq_p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
      seq_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      send_word(32'h44332211, 3'd4, 1'b1);
      bus.input_payload = 32'h0000BBAA;
      bus.input_count   = 3'd2;
      for (int k = 0; k < 6; k++) begin
        expect_beat($sformatf("b2b_beat%0d", k), seq_p[k], seq_l[k]);
        if (k == 3) check("b2b_turnover_ready", 32'(bus.input_ready), 32'd1);
        @(posedge clk);
        #1;
        if (k == 3) bus.input_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_idle_valid", 32'(bus.output_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Backpressure: lane 1 held across two stall cycles, lane 3 never emitted
    bp_pay  = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33};
    bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    send_word(32'h44332211, 3'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.output_ready = bp_rdy[k];
      expect_beat($sformatf("bp_beat%0d", k), bp_pay[k], bp_last[k]);
      @(posedge clk);
      #1;
    end
    bus.output_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_valid", 32'(bus.output_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-word: asynchronous clear, then a fresh single-lane word
    send_word(32'h44332211, 3'd4, 1'b0);
    expect_beat("rmw_beat0", 8'h11, 1'b0);
    @(posedge clk);
    #1;
    expect_beat("rmw_beat1", 8'h22, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rmw_async_valid", 32'(bus.output_valid), 32'd0);
    check("rmw_async_payload", 32'(bus.output_payload), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rmw_post_valid%0d", k), 32'(bus.output_valid), 32'd0);
      check($sformatf("rmw_post_in_ready%0d", k), 32'(bus.input_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    send_word(32'h000000EE, 3'd1, 1'b0);
    expect_beat("rmw_new", 8'hEE, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rmw_new_idle", 32'(bus.output_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Valid/ready width downsizer. Accepts one wide word of N lanes of W bits each. Emits the valid lanes one per beat on a narrow valid/ready stream.
- Used on the emit side of packed datapaths, where parallel lanes must be drained into a single-lane consumer.
- Registered output. Lane order is fixed: lane 0 first.
- When output_ready is held high, back-to-back words stream with no bubble.

Parameters:
- W, 8, width of one lane in bits.
- N, 4, number of lanes per input word (N >= 2).
- CW, $clog2(N+1), width of the lane-count field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- input_valid  input  1  wide word offered.
- input_ready  output  1  block can take a word this cycle.
- input_payload  input  W*N  lanes; lane i = bits [i*W +: W].
- input_count  input  CW  number of valid lanes, starting from lane 0; 0..N.
- output_valid  output  1  narrow beat offered.
- output_ready  input  1  consumer accepts the beat.
- output_payload  output  W  current lane.
- output_last  output  1  current beat is the final lane of its word.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All state clears immediately on rst_n low.
- Reset values:
  - output_valid = 0, output_last = 0, output_payload = 0.
  - Internal state = IDLE, so input_ready = 1 while rst_n is high after reset.
- State: holding register data_q[W*N], remaining-lane counter rem_q[CW], lane index idx_q, FSM {IDLE, DRAIN}.
- Accept condition: a word is accepted on a clk edge where input_valid && input_ready.
- input_ready = (state == IDLE) || (output_valid && output_ready && output_last).
  - Combinational path from output_ready to input_ready. This is intentional; it gives zero-bubble turnover.
- Count handling:
  - input_count > N is treated as N.
  - input_count == 0: the word is accepted and discarded. No beat is produced and the state is unchanged.
- IDLE -> DRAIN: on acceptance with count c >= 1.
  - data_q <= payload, idx_q <= 0, rem_q <= c.
  - Next cycle: output_valid = 1, output_payload = lane 0, output_last = (c == 1).
- In DRAIN, on each output handshake:
  - If it was not the last beat: idx_q++, rem_q--. The next lane appears in the following cycle.
  - If it was the last beat and no new word is accepted in the same cycle: go to IDLE, output_valid <= 0.
  - If it was the last beat and a new word with c >= 1 is accepted in the same cycle: reload and stay in DRAIN. Lane 0 of the new word is presented in the next cycle with no gap.
  - If it was the last beat and a count-0 word is accepted in the same cycle: go to IDLE.
- Backpressure: while output_valid && !output_ready, output_payload, output_last and all internal state hold stable.
- output_payload and output_last are registered and derived from the next idx/rem values. They never glitch mid-beat.
- Latency: 1 cycle from word acceptance to its first beat. A word of c lanes occupies exactly c accepted output beats.
- Throughput: 1 lane per cycle under continuous output_ready.
- Reset mid-word: all remaining lanes are dropped. After rst_n deasserts, output_valid = 0 and input_ready = 1.
- X-safety: input_payload lanes at index >= count are never emitted.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, then release. Required: output_valid = 0, output_last = 0, output_payload = 0, input_ready = 1. Assert rst_n low asynchronously mid-cycle; outputs clear immediately.
- Single full word: W=8, N=4, payload 0x44332211, count 4, output_ready = 1. Required: beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after accept; output_last only on 0x44; input_ready = 0 during the first 3 beats.
- Back-to-back words: accept 0x44332211 (count 4), then 0x0000BBAA (count 2) offered continuously, output_ready = 1. Required: beats 11, 22, 33, 44, AA, BB on 6 consecutive cycles with no bubble; the second word is accepted on the cycle the 0x44 beat handshakes; output_last on 44 and BB.
- Backpressure: payload 0x44332211, count 3, output_ready toggled 1,0,0,1,1. Required: 0x22 is held stable across both stall cycles; sequence is 11, 22, 33 with output_last on 33; 0x44 is never emitted.
- Count edge cases: count 0 -> accepted, no beat, input_ready stays 1. Count 7 -> treated as 4, emits 4 beats. Count 1 with payload 0xFFFFFF5A -> single beat 0x5A with output_last = 1.
- Reset mid-word: accept 0x44332211 (count 4), assert rst_n low after the 0x22 beat. Required: no further beats; after release output_valid = 0, input_ready = 1. A new word 0x000000EE with count 1 then emits 0xEE with output_last = 1.
